demux8_stream: RTL and testbench

DEMUX8_STREAM -- requirements
Module: demux8_stream

---
 rtl/demux8_stream.sv | 90 +++++++++
 tb/tb_demux8_stream.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/demux8_stream.sv
// 1-to-8 stream demultiplexer: each lane is a one-entry register slice with valid/ready handshake.
// Words with an out-of-range select are accepted, discarded and counted in a saturating counter.
module demux8_stream #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [3:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic [WIDTH-1:0] out1_data,
    output logic [WIDTH-1:0] out2_data,
    output logic [WIDTH-1:0] out3_data,
    output logic [WIDTH-1:0] out4_data,
    output logic [WIDTH-1:0] out5_data,
    output logic [WIDTH-1:0] out6_data,
    output logic [WIDTH-1:0] out7_data,
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ready,
    output logic [7:0]       drop_cnt
);

    logic [WIDTH-1:0] data_q [8];
    logic [WIDTH-1:0] data_d [8];
    logic [7:0]       valid_q, valid_d;
    logic [7:0]       drop_q, drop_d;

    logic             sel_ok;
    logic [2:0]       lane;
    logic             in_fire;

    assign sel_ok = ~in_sel[3];
    assign lane   = in_sel[2:0];

    // A lane accepts when empty or draining this same cycle.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (sel_ok) begin
                in_ready = ~valid_q[lane] | out_ready[lane];
            end else begin
                in_ready = 1'b1;
            end
        end
    end

    assign in_fire = in_valid & in_ready;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q & ~out_ready;
        drop_d  = drop_q;
        if (in_fire) begin
            if (sel_ok) begin
                data_d[lane]  = in_data;
                valid_d[lane] = 1'b1;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
            drop_q  <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign out0_data = data_q[0];
    assign out1_data = data_q[1];
    assign out2_data = data_q[2];
    assign out3_data = data_q[3];
    assign out4_data = data_q[4];
    assign out5_data = data_q[5];
    assign out6_data = data_q[6];
    assign out7_data = data_q[7];
    assign out_valid = valid_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_demux8_stream.sv
// Self-checking bench for demux8_stream: queue-based lane model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_demux8_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic [3:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] od [8];
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    demux8_stream #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out0_data (od[0]),
        .out1_data (od[1]),
        .out2_data (od[2]),
        .out3_data (od[3]),
        .out4_data (od[4]),
        .out5_data (od[5]),
        .out6_data (od[6]),
        .out7_data (od[7]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_cnt  (drop_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each lane is a FIFO of accepted words; capacity one is implied by
    // the acceptance rule, and the visible data is the head or the last word seen.
    logic [15:0] mq [8][$];
    logic [15:0] mlast [8];
    int          mdrop;

    function automatic logic exp_ready();
        if (rst) return 1'b0;
        if (in_sel >= 4'd8) return 1'b1;
        return (mq[in_sel].size() == 0) || out_ready[in_sel];
    endfunction

    always @(posedge clk) begin
        logic acc;
        acc = in_valid && exp_ready();
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                mq[k].delete();
                mlast[k] = '0;
            end
            mdrop = 0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (mq[k].size() > 0 && out_ready[k]) mlast[k] = mq[k].pop_front();
            end
            if (acc) begin
                if (in_sel < 4'd8) begin
                    mq[in_sel].push_back(in_data);
                    mlast[in_sel] = in_data;
                end else if (mdrop < 255) begin
                    mdrop++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [7:0] ev;
            for (int k = 0; k < 8; k++) begin
                ev[k] = mq[k].size() != 0;
                chk($sformatf("model_data%0d", k), od[k], mq[k].size() != 0 ? mq[k][0] : mlast[k]);
            end
            chk("model_in_ready", in_ready, exp_ready());
            chk("model_out_valid", out_valid, ev);
            chk("model_drop_cnt", drop_cnt, mdrop);
        end
    end

    task automatic drive(input logic r, input logic v, input logic [3:0] s, input logic [15:0] d,
                         input logic [7:0] ordy);
        @(posedge clk);
        #1;
        rst = r; in_valid = v; in_sel = s; in_data = d; out_ready = ordy;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        at_neg();
        chk("reset_out_valid", out_valid, 8'h00);
        chk("reset_drop", drop_cnt, 8'h00);
        chk("reset_in_ready", in_ready, 1'b0);

        // Single word, first cycle out of reset
        drive(1'b0, 1'b1, 4'd3, 16'hA5A5, 8'h00);
        at_neg();
        chk("first_in_ready", in_ready, 1'b1);
        drive(1'b0, 1'b0, 4'd3, 16'h0000, 8'h00);
        at_neg();
        chk("single_valid", out_valid, 8'h08);
        chk("single_data3", od[3], 16'hA5A5);
        chk("single_ready_drop", in_ready, 1'b0);

        // Lane 5 streaming under continuous drain
        drive(1'b0, 1'b1, 4'd5, 16'h0100, 8'h00);
        for (int i = 1; i <= 4; i++) begin
            if (i <= 3) drive(1'b0, 1'b1, 4'd5, 16'(i), 8'h20);
            else        drive(1'b0, 1'b0, 4'd5, 16'h0, 8'h20);
            at_neg();
            chk("stream_valid5", out_valid[5], 1'b1);
            chk("stream_data5", od[5], (i == 1) ? 32'h100 : 32'(i - 1));
        end
        drive(1'b0, 1'b0, 4'd5, 16'h0, 8'h00);
        at_neg();
        chk("stream_drained", out_valid, 8'h08);
        chk("stream_hold5", od[5], 16'h0003);

        // Invalid select saturation
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 1'b1, 4'hC, 16'(i), 8'h00);
            at_neg();
            chk("inv_ready", in_ready, 1'b1);
            chk("inv_valid", out_valid, 8'h08);
        end
        drive(1'b0, 1'b0, 4'h0, 16'h0, 8'h00);
        at_neg();
        chk("inv_sat", drop_cnt, 8'hFF);

        // Independent lanes
        drive(1'b0, 1'b1, 4'd0, 16'hBEEF, 8'h00);
        drive(1'b0, 1'b1, 4'd1, 16'h0001, 8'h00);
        at_neg();
        chk("indep_ready", in_ready, 1'b1);
        drive(1'b0, 1'b0, 4'd0, 16'h0, 8'h00);
        at_neg();
        chk("indep_data1", od[1], 16'h0001);
        chk("indep_data0", od[0], 16'hBEEF);
        chk("indep_valid", out_valid, 8'h0B);
        chk("indep_ready_full0", in_ready, 1'b0);

        // Reset mid-flight with all lanes full and drop_cnt=7
        drive(1'b1, 1'b0, 4'd0, 16'h0, 8'h00);
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 4'hF, 16'h0, 8'h00);
        for (int k = 0; k < 8; k++) drive(1'b0, 1'b1, 4'(k), 16'(16'h1000 + k), 8'h00);
        drive(1'b0, 1'b0, 4'd0, 16'h0, 8'h00);
        at_neg();
        chk("pre_rst_valid", out_valid, 8'hFF);
        chk("pre_rst_drop", drop_cnt, 8'h07);
        chk("pre_rst_data7", od[7], 16'h1007);
        drive(1'b1, 1'b1, 4'd2, 16'h5555, 8'hFF);
        at_neg();
        chk("rst_in_ready", in_ready, 1'b0);
        drive(1'b0, 1'b0, 4'd2, 16'h0, 8'h00);
        at_neg();
        chk("post_rst_valid", out_valid, 8'h00);
        chk("post_rst_drop", drop_cnt, 8'h00);
        for (int k = 0; k < 8; k++) chk("post_rst_data", od[k], 16'h0000);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] s;
            s = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), s,
                  16'($urandom), 8'($urandom));
        end
        drive(1'b0, 1'b0, 4'd0, 16'h0, 8'hFF);
        at_neg();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
